// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-strobe bundle between the CPU MEM stage and mem_access_ctrl.
// The slave modport is the controller's view; master is the CPU/memory side.
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWrite;
    logic [1:0]            reqSize;
    logic                  reqSigned;
    logic [31:0]           reqAddr;
    logic [DATA_WIDTH-1:0] reqWData;
    logic                  respValid;
    logic [DATA_WIDTH-1:0] respRData;
    logic                  respError;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic                  memTrigWrite;
    logic                  memTrigRead;
    logic [DATA_WIDTH-1:0] memReadData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memReadData,
        output reqReady, respValid, respRData, respError,
        output memAddress, memWriteData, memTrigWrite, memTrigRead
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWData, memReadData,
        input  reqReady, respValid, respRData, respError,
        input  memAddress, memWriteData, memTrigWrite, memTrigRead
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the word-addressed strobe memory: RMW for sub-word stores, big-endian lanes.
// Define MEM_CTRL_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int READ_LAT   = 1
) (
    input  logic            clk,
    input  logic            reset,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} ctrlState_t;

    ctrlState_t            state;
    ctrlState_t            stateNext;
    logic [2:0]            rdCnt;
    logic                  rdLast;
    logic                  handshake;
    logic                  reqErr;
    logic [1:0]            alignedOff;
    logic                  wrReg;
    logic [1:0]            sizeReg;
    logic                  sgnReg;
    logic [1:0]            offReg;
    logic [DATA_WIDTH-1:0] wdataReg;
    logic [DATA_WIDTH-1:0] rdWord;
    logic                  reqReadyC;
    logic                  respValidC;
    logic                  trigReadC;
    logic                  trigWriteC;

    // Big-endian lane pick: byte offset 0 is bits [31:24].
    function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[(3 - int'(off)) * 8 +: 8];
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   r = sgn ? 32'(b) : {24'h0, b};
            2'b01:   r = sgn ? 32'(h) : {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r[(3 - int'(off)) * 8 +: 8] = wdata[7:0];
            2'b01: begin
                if (off[1]) r[15:0]  = wdata[15:0];
                else        r[31:16] = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign handshake = bus.reqValid && (state == IDLE);
    assign rdLast    = (rdCnt == 3'(READ_LAT - 1));

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    logic misAligned;
    assign misAligned = ((bus.reqSize == 2'b01) && bus.reqAddr[0]) ||
                        ((bus.reqSize == 2'b10) && (bus.reqAddr[1:0] != 2'b00));
    assign reqErr     = (bus.reqSize == 2'b11) || (|bus.reqAddr[31:ADDR_WIDTH+2]) || misAligned;
    assign alignedOff = bus.reqAddr[1:0];
`else
    assign reqErr     = (bus.reqSize == 2'b11) || (|bus.reqAddr[31:ADDR_WIDTH+2]);
    assign alignedOff = (bus.reqSize == 2'b01) ? {bus.reqAddr[1], 1'b0} :
                        (bus.reqSize == 2'b10) ? 2'b00 : bus.reqAddr[1:0];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        reqReadyC  = 1'b0;
        respValidC = 1'b0;
        trigReadC  = 1'b0;
        trigWriteC = 1'b0;
        case (state)
            IDLE: begin
                reqReadyC = 1'b1;
                if (handshake) begin
                    if (reqErr)                                     stateNext = RESP;
                    else if (bus.reqWrite && bus.reqSize == 2'b10) stateNext = WR;
                    else                                            stateNext = RD;
                end
            end
            RD: begin
                trigReadC = 1'b1;
                if (rdLast) stateNext = wrReg ? MERGE : RESP;
            end
            MERGE: stateNext = WR;
            WR: begin
                trigWriteC = 1'b1;
                stateNext  = RESP;
            end
            RESP: begin
                respValidC = 1'b1;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.reqReady     = reqReadyC;
    assign bus.respValid    = respValidC;
    assign bus.memTrigRead  = trigReadC;
    assign bus.memTrigWrite = trigWriteC;

    // Request fields are only consumed after a handshake, so they carry no reset.
    always_ff @(posedge clk) begin
        if (handshake) begin
            sizeReg  <= bus.reqSize;
            sgnReg   <= bus.reqSigned;
            offReg   <= alignedOff;
            wdataReg <= bus.reqWData;
        end
        if (state == RD && rdLast) rdWord <= bus.memReadData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrReg            <= 1'b0;
            rdCnt            <= '0;
            bus.memAddress   <= '0;
            bus.memWriteData <= '0;
            bus.respRData    <= '0;
            bus.respError    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdCnt <= '0;
                    if (handshake) begin
                        wrReg         <= bus.reqWrite;
                        bus.respRData <= '0;
                        bus.respError <= reqErr;
                        if (!reqErr) begin
                            bus.memAddress <= bus.reqAddr[ADDR_WIDTH+1:2];
                            if (bus.reqWrite && bus.reqSize == 2'b10) bus.memWriteData <= bus.reqWData;
                        end
                    end
                end
                RD: begin
                    rdCnt <= rdCnt + 3'd1;
                    if (rdLast && !wrReg)
                        bus.respRData <= extractLoad(bus.memReadData, sizeReg, sgnReg, offReg);
                end
                MERGE: bus.memWriteData <= mergeStore(rdWord, wdataReg, sizeReg, offReg);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of load/store requests against a behavioural 128-word memory.
module tb_mem_access_ctrl;
    localparam int AW = 7;
    localparam int RL = 1;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
        int          expLat;
        int          expRd;
        int          expWr;
        bit          memChk;
        int          memIdx;
        logic [31:0] memExp;
    } vecT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nCmp = 0;
    int   nFail = 0;
    vecT  vecs[$];
    logic [31:0] memArr [0:127];

    mem_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .READ_LAT(RL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.memTrigWrite) memArr[bus.memAddress] <= bus.memWriteData;
    assign bus.memReadData = memArr[bus.memAddress];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic vecT mk(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr,
                               input int expLat, input int expRd, input int expWr,
                               input bit memChk, input int memIdx, input logic [31:0] memExp);
        vecT v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.expData = expData; v.expErr = expErr; v.expLat = expLat;
        v.expRd = expRd; v.expWr = expWr; v.memChk = memChk; v.memIdx = memIdx; v.memExp = memExp;
        return v;
    endfunction

    // Issues one request and watches it until respValid; latency counted in cycles after the handshake.
    task automatic doTxn(input vecT v, output logic [31:0] rdata, output logic err,
                         output int lat, output int nRd, output int nWr, output int both);
        int guard;
        bit found;
        @(negedge clk);
        guard = 0;
        while (!bus.reqReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.reqValid  = 1'b1;
        bus.reqWrite  = v.wr;
        bus.reqSize   = v.size;
        bus.reqSigned = v.sgn;
        bus.reqAddr   = v.addr;
        bus.reqWData  = v.wdata;
        @(negedge clk);
        // Keep reqValid high with junk fields while busy; the controller must ignore them.
        bus.reqWrite = ~v.wr;
        bus.reqSize  = 2'b11;
        bus.reqAddr  = 32'hFFFF_FFFF;
        bus.reqWData = 32'hDEAD_BEEF;
        lat = 1; nRd = 0; nWr = 0; both = 0; rdata = '0; err = 1'b0; found = 1'b0;
        while (lat <= 20 && !found) begin
            if (bus.memTrigRead) nRd++;
            if (bus.memTrigWrite) nWr++;
            if (bus.memTrigRead && bus.memTrigWrite) both++;
            if (bus.respValid) begin
                rdata = bus.respRData;
                err   = bus.respError;
                found = 1'b1;
                bus.reqValid = 1'b0;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!found) begin
            lat = -1;
            bus.reqValid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat, nRd, nWr, both, seen;

        bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'b00;
        bus.reqSigned = 1'b0; bus.reqAddr = '0; bus.reqWData = '0;

        // wr size sgn addr wdata | expData err lat rd wr | memChk idx memExp
        vecs.push_back(mk(1, 2'b10, 0, 32'h4, 32'hAAAAAAAA, 32'h0, 0, 2, 0, 1, 1, 1, 32'hAAAAAAAA));
        vecs.push_back(mk(1, 2'b10, 0, 32'h8, 32'hBBBBCCCC, 32'h0, 0, 2, 0, 1, 1, 2, 32'hBBBBCCCC));
        vecs.push_back(mk(1, 2'b10, 0, 32'hC, 32'hBCBCBCBC, 32'h0, 0, 2, 0, 1, 1, 3, 32'hBCBCBCBC));
        vecs.push_back(mk(1, 2'b10, 0, 32'h0, 32'hABCDABCD, 32'h0, 0, 2, 0, 1, 1, 0, 32'hABCDABCD));
        vecs.push_back(mk(1, 2'b00, 0, 32'h6, 32'h00000055, 32'h0, 0, RL+3, RL, 1, 1, 1, 32'hAAAA55AA));
        vecs.push_back(mk(0, 2'b01, 1, 32'hA, 32'h0, 32'hFFFFCCCC, 0, RL+1, RL, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 0, 32'hA, 32'h0, 32'h0000CCCC, 0, RL+1, RL, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h8, 32'h0, 32'hFFFFFFBB, 0, RL+1, RL, 0, 0, 0, 32'h0));
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 2'b10, 0, 32'h2, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h9, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0));
`else
        vecs.push_back(mk(0, 2'b10, 0, 32'h2, 32'h0, 32'hABCDABCD, 0, RL+1, RL, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h9, 32'h0, 32'hFFFFBBBB, 0, RL+1, RL, 0, 0, 0, 32'h0));
`endif
        vecs.push_back(mk(0, 2'b10, 0, 32'h200, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h4, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h6, 32'h00001234, 32'h0, 0, RL+3, RL, 1, 1, 1, 32'hAAAA1234));
        vecs.push_back(mk(0, 2'b00, 0, 32'h7, 32'h0, 32'h00000034, 0, RL+1, RL, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h4, 32'h0, 32'hAAAA1234, 0, RL+1, RL, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h4, 32'h0, 32'h0, 1, 1, 0, 0, 1, 1, 32'hAAAA1234));
        vecs.push_back(mk(1, 2'b00, 0, 32'h3, 32'hFFFFFF77, 32'h0, 0, RL+3, RL, 1, 1, 0, 32'hABCDAB77));
        vecs.push_back(mk(1, 2'b00, 0, 32'h80000000, 32'h11, 32'h0, 1, 1, 0, 0, 1, 0, 32'hABCDAB77));
        vecs.push_back(mk(0, 2'b00, 1, 32'h1, 32'h0, 32'hFFFFFFCD, 0, RL+1, RL, 0, 0, 0, 32'h0));
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
        vecs.push_back(mk(1, 2'b01, 0, 32'h5, 32'h0000BEEF, 32'h0, 1, 1, 0, 0, 1, 1, 32'hAAAA1234));
`else
        vecs.push_back(mk(1, 2'b01, 0, 32'h5, 32'h0000BEEF, 32'h0, 0, RL+3, RL, 1, 1, 1, 32'hBEEF1234));
`endif

        #12;
        check("rst reqReady", 32'(bus.reqReady), 32'd1);
        check("rst respValid", 32'(bus.respValid), 32'd0);
        check("rst respRData", bus.respRData, 32'h0);
        check("rst respError", 32'(bus.respError), 32'd0);
        check("rst memTrigRead", 32'(bus.memTrigRead), 32'd0);
        check("rst memTrigWrite", 32'(bus.memTrigWrite), 32'd0);
        check("rst memAddress", 32'(bus.memAddress), 32'd0);
        check("rst memWriteData", bus.memWriteData, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            doTxn(vecs[i], rdata, err, lat, nRd, nWr, both);
            check($sformatf("v%0d rdata", i), rdata, vecs[i].expData);
            check($sformatf("v%0d error", i), 32'(err), 32'(vecs[i].expErr));
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
            check($sformatf("v%0d readStrobes", i), 32'(nRd), 32'(vecs[i].expRd));
            check($sformatf("v%0d writeStrobes", i), 32'(nWr), 32'(vecs[i].expWr));
            check($sformatf("v%0d strobeOverlap", i), 32'(both), 32'd0);
            if (vecs[i].memChk) begin
                @(negedge clk);
                check($sformatf("v%0d memWord", i), memArr[vecs[i].memIdx], vecs[i].memExp);
            end else begin
                @(negedge clk);
                check($sformatf("v%0d readyAfterResp", i), 32'(bus.reqReady), 32'd1);
            end
        end

        // Reset in the middle of a load's read phase.
        bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqSize = 2'b10;
        bus.reqSigned = 1'b0; bus.reqAddr = 32'h4;
        @(negedge clk);
        bus.reqValid = 1'b0;
        check("midrst readActive", 32'(bus.memTrigRead), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst readDropped", 32'(bus.memTrigRead), 32'd0);
        check("midrst noResp", 32'(bus.respValid), 32'd0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.respValid || bus.memTrigRead || bus.memTrigWrite) seen++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.respValid || bus.memTrigRead || bus.memTrigWrite) seen++;
        end
        check("midrst quietAfter", 32'(seen), 32'd0);
        check("midrst readyAfter", 32'(bus.reqReady), 32'd1);

        doTxn(mk(0, 2'b10, 0, 32'hC, 32'h0, 32'hBCBCBCBC, 0, RL+1, RL, 0, 0, 0, 32'h0),
              rdata, err, lat, nRd, nWr, both);
        check("postrst rdata", rdata, 32'hBCBCBCBC);
        check("postrst error", 32'(err), 32'd0);
        check("postrst latency", 32'(lat), 32'(RL + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the CPU MEM stage and the word-addressed `memory` block (128 x 32-bit, strobe-driven).
- Accepts one byte/half/word request per handshake and generates `memTrigRead` / `memTrigWrite` strobes.
- Performs read-modify-write for sub-word stores, and extraction plus sign/zero extension for loads.
- Returns a single-cycle response; big-endian byte order.

Parameters:
- ADDR_WIDTH, 7, memory word-address width (depth = 2^ADDR_WIDTH words)
- DATA_WIDTH, 32, memory word width; only 32 is supported
- READ_LAT, 1, cycles `memTrigRead` is held high before `memReadData` is sampled (1..4)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- reqValid  in  1  request present
- reqReady  out  1  controller can accept; transfer when reqValid & reqReady
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 half, 10 word; 11 is illegal
- reqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- reqAddr  in  32  byte address
- reqWData  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- respValid  out  1  one-cycle response pulse
- respRData  out  32  load result, extended; 0 for stores and errors
- respError  out  1  valid with respValid: misaligned, out-of-range or illegal size
- memAddress  out  ADDR_WIDTH  word address = reqAddr[ADDR_WIDTH+1:2]
- memWriteData  out  32  word to write
- memTrigWrite  out  1  write strobe
- memTrigRead  out  1  read strobe
- memReadData  in  32  word from memory

Behaviour:
- Reset values (async): state IDLE; reqReady=1; respValid=0; respRData=0; respError=0; memTrigRead=0; memTrigWrite=0; memAddress=0; memWriteData=0.
- When reset is asserted mid-operation, the operation is abandoned immediately: strobes drop in the same instant and no response is issued.
- States: IDLE, RD, MERGE, WR, RESP.
- reqReady=1 only in IDLE.
- On handshake, the controller latches addr, size, signed, write and wdata, then classifies the request as error or legal.
- Error checks:
  - reqSize==11.
  - reqAddr[31:ADDR_WIDTH+2]!=0.
  - Misalignment: half with addr[0]!=0, or word with addr[1:0]!=0.
- Error path: IDLE->RESP; no strobe is ever asserted.
- Transitions from IDLE:
  - word store: ->WR
  - sub-word store or any load: ->RD
- RD:
  - memTrigRead=1 for exactly READ_LAT cycles.
  - memReadData is captured on the last of those cycles.
  - Then ->RESP for a load, ->MERGE for a store.
- MERGE (1 cycle, no strobe): builds memWriteData by replacing the selected lane of the captured word.
  - Byte lanes: offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - Half lanes: offset 0 = [31:16], 2 = [15:0].
  - Then ->WR.
- WR:
  - memTrigWrite=1 for exactly 1 cycle; memAddress and memWriteData are stable for that whole cycle.
  - Then ->RESP.
- RESP:
  - respValid=1 for 1 cycle, then ->IDLE.
  - For loads, respRData = the lane extracted per offset, extended per reqSigned; a word load is passed through unchanged.
- Latency, handshake to respValid:
  - word store: 2 cycles
  - load: READ_LAT+1 cycles
  - sub-word store: READ_LAT+3 cycles
  - error: 1 cycle
- memTrigRead and memTrigWrite are never high together.
- memAddress holds its last value outside RD/WR.
- Back-to-back: the next request is accepted in the cycle after RESP.
- reqValid held with changing fields while not ready is ignored; only the handshake cycle is sampled.

Optional Feature:
- MEM_CTRL_MISALIGN_TRAP_EN
- Defined: misaligned half/word accesses produce respError=1 with no memory access (as above).
- Undefined:
  - Misalignment is not an error; the address is forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.
  - Out-of-range and illegal-size checks remain active.

Test Plan:
- Word store addr 0x0, data 0xABCDABCD -> memTrigWrite one pulse at memAddress 0, memWriteData 0xABCDABCD; respValid 2 cycles after the handshake with respError=0.
- Preload word 1 = 0xAAAAAAAA; byte store addr 0x6, data 0x55 -> RD then WR; word 1 becomes 0xAAAA55AA; respValid at READ_LAT+3.
- Preload word 2 = 0xBBBBCCCC; lh signed addr 0xA -> respRData 0xFFFFCCCC; lhu -> 0x0000CCCC; lb signed addr 0x8 -> 0xFFFFFFBB.
- Word load addr 0x2:
  - with MEM_CTRL_MISALIGN_TRAP_EN: respError=1, respRData=0, no strobe.
  - without it: returns word 0.
- Load addr 0x200 (word 128, out of range) -> respError=1 after 1 cycle, no strobe; a request with reqSize=11 behaves the same.
- Assert reset during RD of a load -> memTrigRead drops immediately, no respValid, reqReady=1 after release; the next word load to addr 0xC returns preloaded 0xBCBCBCBC.
